// File: rtl/instr_fetch_unit_if.sv
// naive_bus: simple request/grant read/write bus.
// master drives requests; slave returns grant and read data.
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  modport master (
    output rd_req, rd_addr,
    output wr_req, wr_addr, wr_data, wr_be,
    input  rd_gnt, rd_data
  );

  modport slave (
    input  rd_req, rd_addr,
    input  wr_req, wr_addr, wr_data, wr_be,
    output rd_gnt, rd_data
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: naive_bus read master feeding a {pc,instr} FIFO.
// Ports: clk, rst_n, bus (master), redirect_en/pc, if_valid/ready/pc/instr.
module instr_fetch_unit #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  naive_bus.master    bus,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_started;
  logic          r_inflight;
  logic          r_stale;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_inflight_pc;
  logic [31:0]   r_last_pc;
  logic [31:0]   r_last_instr;

  logic          w_room;
  logic          w_req;
  logic          w_gnt;
  logic          w_push;
  logic          w_pop;
  logic [CW:0]   w_occ;
  ent_t          w_head;
  logic          w_unused_pc_lsb;

  assign w_unused_pc_lsb = ^redirect_pc[1:0];

  // Outstanding read counts against FIFO room so a push never overflows.
  assign w_occ  = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_room = w_occ < (CW+1)'(FIFO_DEPTH);
  assign w_req  = r_started & ~redirect_en & w_room;
  assign w_gnt  = w_req & bus.rd_gnt;

  // Redirect wins: return data and pop in that cycle are dropped.
  assign w_push = r_inflight & ~r_stale & ~redirect_en;
  assign w_pop  = if_valid & if_ready & ~redirect_en;

  assign bus.rd_req  = w_req;
  assign bus.rd_addr = r_started ? r_fetch_pc : 32'h0;
  assign bus.wr_req  = 1'b0;
  assign bus.wr_addr = 32'h0;
  assign bus.wr_data = 32'h0;
  assign bus.wr_be   = 4'h0;

  assign if_valid = (r_count != '0);
  assign w_head   = r_mem[r_rptr];
  // Head is shown while valid; otherwise the last shown values hold.
  assign if_pc    = if_valid ? w_head.pc    : r_last_pc;
  assign if_instr = if_valid ? w_head.instr : r_last_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_started     <= 1'b0;
      r_inflight    <= 1'b0;
      r_stale       <= 1'b0;
      r_fetch_pc    <= BOOT_ADDR;
      r_inflight_pc <= '0;
      r_last_pc     <= '0;
      r_last_instr  <= '0;
    end else begin
      r_started    <= 1'b1;
      r_last_pc    <= if_pc;
      r_last_instr <= if_instr;
      r_stale      <= redirect_en & r_inflight;
      if (redirect_en) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        r_inflight <= 1'b0;
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else begin
        r_inflight <= w_gnt;
        if (w_gnt) begin
          r_inflight_pc <= r_fetch_pc;
          r_fetch_pc    <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_mem[r_wptr] <= '{pc: r_inflight_pc, instr: bus.rd_data};
          r_wptr        <= r_wptr + AW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + AW'(1);
        end
        unique case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && r_count == CW'(FIFO_DEPTH))
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// Cycle vector table plus a grant/pop scoreboard against a ROM model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        gnt_en;

  int checks;
  int errors;
  int n_grants;
  int n_pc8;

  naive_bus bus_if ();

  instr_fetch_unit #(
    .BOOT_ADDR  (32'h0),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_instr    (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0)        return 32'h0001_0537;
    else if (a == 32'h50)  return 32'h0ec5_d863;
    else if (a < 32'h400)  return 32'hA000_0000 | a;
    else                   return 32'h0;
  endfunction

  // ROM slave: one-cycle read latency, grant controlled by the bench.
  assign bus_if.rd_gnt = gnt_en;
  always @(posedge clk) begin
    if (bus_if.rd_req && bus_if.rd_gnt)
      bus_if.rd_data <= rom_word(bus_if.rd_addr);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sbq[$];

  // Scoreboard: grants push expected words, handshakes pop and compare.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (redirect_en) begin
        sbq.delete();
      end else begin
        if (if_valid && if_ready) begin
          if (if_pc == 32'h8) n_pc8++;
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got pc %h expected none", if_pc);
          end else begin
            e = sbq.pop_front();
            chk("sb_pc", if_pc, e.pc);
            chk("sb_instr", if_instr, e.instr);
          end
        end
        if (bus_if.rd_req && bus_if.rd_gnt) begin
          sbq.push_back('{pc: bus_if.rd_addr,
                          instr: rom_word(bus_if.rd_addr)});
          n_grants++;
        end
      end
    end
  end

  always @(negedge rst_n) sbq.delete();

  typedef struct {
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vt[6];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(if_valid), 32'h0);
    chk({tag, "_pc"}, if_pc, 32'h0);
    chk({tag, "_instr"}, if_instr, 32'h0);
    chk({tag, "_req"}, 32'(bus_if.rd_req), 32'h0);
    chk({tag, "_addr"}, bus_if.rd_addr, 32'h0);
  endtask

  // Leaves the bench at cycle 0 (first cycle after reset release).
  task automatic do_reset(input logic rdy, input logic g);
    rst_n       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    if_ready    = rdy;
    gnt_en      = g;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_addr(input logic [31:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus_if.rd_req && bus_if.rd_addr == a) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  task automatic chk_cycle(input string tag, input logic v,
                           input logic [31:0] pc);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(if_valid), 32'(v));
    if (v) begin
      chk({tag, "_pc"}, if_pc, pc);
      chk({tag, "_instr"}, if_instr, rom_word(pc));
    end
    cyc(1);
  endtask

  initial begin
    bit ok;
    checks   = 0;
    errors   = 0;
    n_grants = 0;
    n_pc8    = 0;
    rst_n    = 1'b0;
    gnt_en   = 1'b1;
    if_ready = 1'b1;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    bus_if.rd_data = 32'h0;

    vt[0] = '{1'b0, 32'h0,  1'b0, 32'h0, 32'h0};
    vt[1] = '{1'b1, 32'h0,  1'b0, 32'h0, 32'h0};
    vt[2] = '{1'b1, 32'h4,  1'b0, 32'h0, 32'h0};
    vt[3] = '{1'b1, 32'h8,  1'b1, 32'h0, 32'h0001_0537};
    vt[4] = '{1'b1, 32'hC,  1'b1, 32'h4, rom_word(32'h4)};
    vt[5] = '{1'b1, 32'h10, 1'b1, 32'h8, rom_word(32'h8)};

    // Sequential fetch from reset.
    rst_n = 1'b0;
    cyc(2);
    chk_reset_state("rst");
    do_reset(1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("seq%0d_req", k), 32'(bus_if.rd_req), 32'(vt[k].e_req));
      chk($sformatf("seq%0d_addr", k), bus_if.rd_addr, vt[k].e_addr);
      chk($sformatf("seq%0d_valid", k), 32'(if_valid), 32'(vt[k].e_valid));
      chk($sformatf("seq%0d_pc", k), if_pc, vt[k].e_pc);
      chk($sformatf("seq%0d_instr", k), if_instr, vt[k].e_instr);
      cyc(1);
    end
    cyc(6);

    // Backpressure: FIFO fills with exactly four entries.
    do_reset(1'b0, 1'b1);
    n_grants = 0;
    cyc(10);
    @(negedge clk);
    chk("bp_grants", 32'(n_grants), 32'd4);
    chk("bp_req", 32'(bus_if.rd_req), 32'h0);
    chk("bp_valid", 32'(if_valid), 32'h1);
    chk("bp_head", if_pc, 32'h0);
    cyc(1);
    if_ready = 1'b1;
    cyc(10);

    // Grant stall at 0x8.
    do_reset(1'b1, 1'b1);
    n_pc8 = 0;
    wait_addr(32'h8, ok);
    chk("gs_reach8", 32'(ok), 32'h1);
    gnt_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("gs_req", 32'(bus_if.rd_req), 32'h1);
      chk("gs_addr", bus_if.rd_addr, 32'h8);
      cyc(1);
    end
    gnt_en = 1'b1;
    cyc(10);
    chk("gs_once8", 32'(n_pc8), 32'h1);

    // Redirect with one read in flight and two entries buffered.
    do_reset(1'b0, 1'b1);
    cyc(4);
    redirect_en = 1'b1;
    redirect_pc = 32'h50;
    @(negedge clk);
    chk("rd_req_low", 32'(bus_if.rd_req), 32'h0);
    cyc(1);
    redirect_en = 1'b0;
    if_ready    = 1'b1;
    @(negedge clk);
    chk("rd_addr", bus_if.rd_addr, 32'h50);
    chk("rd_valid0", 32'(if_valid), 32'h0);
    cyc(1);
    chk_cycle("rd_c6", 1'b0, 32'h0);
    chk_cycle("rd_c7", 1'b1, 32'h50);
    cyc(4);

    // Misaligned redirect concurrent with a pop.
    do_reset(1'b1, 1'b1);
    cyc(5);
    redirect_en = 1'b1;
    redirect_pc = 32'h13;
    @(negedge clk);
    chk("mr_popping", 32'(if_valid & if_ready), 32'h1);
    cyc(1);
    redirect_en = 1'b0;
    @(negedge clk);
    chk("mr_valid0", 32'(if_valid), 32'h0);
    chk("mr_addr", bus_if.rd_addr, 32'h10);
    cyc(1);
    chk_cycle("mr_c7", 1'b0, 32'h0);
    chk_cycle("mr_c8", 1'b1, 32'h10);
    cyc(4);

    // Asynchronous reset during steady fetch at 0x40.
    wait_addr(32'h40, ok);
    chk("mid_reach40", 32'(ok), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_reset_state("mid");
    cyc(1);
    rst_n = 1'b1;
    chk_cycle("mid_c0", 1'b0, 32'h0);
    chk_cycle("mid_c1", 1'b0, 32'h0);
    chk_cycle("mid_c2", 1'b0, 32'h0);
    chk_cycle("mid_c3", 1'b1, 32'h0);
    cyc(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
